// File: rtl/axi_sram_slv_if.sv
// ----------------------------------------------------------------------------
// axi_sram_slv_if
// AXI4-Lite bundle between the interconnect master port and the SRAM slave.
//   AR : ar_valid, ar_ready, ar_addr
//   R  : r_valid, r_ready, r_data, r_resp
//   AW : aw_valid, aw_ready, aw_addr
//   W  : w_valid, w_ready, w_data, w_strb
//   B  : b_valid, b_ready, b_resp
// Modports: master (interconnect side), slave (memory side).
// ----------------------------------------------------------------------------
interface axi_sram_slv_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;

    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;

    logic                w_valid;
    logic                w_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;

    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;

    modport master (
        output ar_valid, ar_addr, input  ar_ready,
        input  r_valid, r_data, r_resp, output r_ready,
        output aw_valid, aw_addr, input  aw_ready,
        output w_valid, w_data, w_strb, input  w_ready,
        input  b_valid, b_resp, output b_ready
    );

    modport slave (
        input  ar_valid, ar_addr, output ar_ready,
        output r_valid, r_data, r_resp, input  r_ready,
        input  aw_valid, aw_addr, output aw_ready,
        input  w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input  b_ready
    );
endinterface

// File: rtl/axi_sram_slv.sv
// ----------------------------------------------------------------------------
// axi_sram_slv
// AXI4-Lite memory slave modelling the SRAM behind the interconnect. A word
// array with a programmable access latency; independent read and write
// engines, one outstanding transaction each.
//
// Ports:
//   clk_i  : clock, all logic on posedge
//   rst_i  : synchronous reset, active-low
//   axi    : axi_sram_slv_if.slave (AR/R/AW/W/B channels)
//
// Optional feature: AXI_SRAM_RAND_DELAY_EN adds 0..3 pseudo-random extra
// cycles (4-bit LFSR, x^4+x^3+1) to every transaction. Undefined: latency is
// exactly LATENCY.
//
// Read FSM
//   state  | meaning
//   R_IDLE | ar_ready high, waiting for an address
//   R_WAIT | counting down access latency
//   R_RESP | r_valid high, payload held until r_ready
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W in any order
//   W_WAIT | both latched, counting down access latency
//   W_RESP | b_valid high, waiting for b_ready
// ----------------------------------------------------------------------------
module axi_sram_slv #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
    parameter int                LATENCY    = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    axi_sram_slv_if.slave  axi
);

    localparam int                DEPTH       = 1 << DEPTH_LOG2;
    localparam int                CNT_W       = 5;
    localparam int                NB          = DATA_W / 8;
    localparam logic [ADDR_W-1:0] SPAN        = ADDR_W'(DEPTH) << 2;
    localparam logic [CNT_W-1:0]  CNT_INIT    = CNT_W'(LATENCY - 1);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    r_state_t          r_state_q;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_valid_q;
    logic [DATA_W-1:0] r_data_q;
    logic [1:0]        r_resp_q;

    w_state_t          w_state_q;
    logic [CNT_W-1:0]  w_cnt_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [NB-1:0]     w_strb_q;
    logic              aw_got_q;
    logic              w_got_q;
    logic              b_valid_q;
    logic [1:0]        b_resp_q;

    // Latency counter start value, shared by both engines.
    logic [CNT_W-1:0]  cnt_load_d;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [3:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lfsr_q <= 4'b1001;
        end else begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    assign cnt_load_d = CNT_INIT + CNT_W'(lfsr_q[1:0]);
`else
    assign cnt_load_d = CNT_INIT;
`endif

    // Address decode; the subtraction wraps, so addresses below BASE land far
    // above SPAN and decode as out of range.
    logic [ADDR_W-1:0]     r_off, w_off;
    logic                  r_hit, w_hit;
    logic [DEPTH_LOG2-1:0] r_idx, w_idx;

    assign r_off = r_addr_q - BASE;
    assign r_hit = r_off < SPAN;
    assign r_idx = r_off[DEPTH_LOG2+1:2];
    assign w_off = aw_addr_q - BASE;
    assign w_hit = w_off < SPAN;
    assign w_idx = w_off[DEPTH_LOG2+1:2];

    logic ar_hs, aw_hs, w_hs;
    assign ar_hs = axi.ar_valid && (r_state_q == R_IDLE);
    assign aw_hs = axi.aw_valid && (w_state_q == W_IDLE) && !aw_got_q;
    assign w_hs  = axi.w_valid  && (w_state_q == W_IDLE) && !w_got_q;

    // ---------------- read engine ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_addr_q  <= axi.ar_addr;
                        r_cnt_q   <= cnt_load_d;
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q == '0) begin
                        r_data_q  <= r_hit ? mem_q[r_idx] : '0;
                        r_resp_q  <= r_hit ? RESP_OKAY : RESP_DECERR;
                        r_valid_q <= 1'b1;
                        r_state_q <= R_RESP;
                    end else begin
                        r_cnt_q <= r_cnt_q - CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (axi.r_ready) begin
                        r_valid_q <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- write engine ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= axi.aw_addr;
                        aw_got_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_q <= axi.w_data;
                        w_strb_q <= axi.w_strb;
                        w_got_q  <= 1'b1;
                    end
                    // Start timing on the edge that completes the pair.
                    if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                        w_cnt_q   <= cnt_load_d;
                        w_state_q <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt_q == '0) begin
                        b_resp_q  <= w_hit ? RESP_OKAY : RESP_DECERR;
                        b_valid_q <= 1'b1;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        w_state_q <= W_RESP;
                    end else begin
                        w_cnt_q <= w_cnt_q - CNT_W'(1);
                    end
                end
                W_RESP: begin
                    if (axi.b_ready) begin
                        b_valid_q <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Array commit. Gated by rst_i so a reset on the commit edge drops the
    // write. The read sample above uses the pre-edge contents, so a same-edge
    // read of this word returns the old data.
    logic mem_we;
    assign mem_we = rst_i && (w_state_q == W_WAIT) && (w_cnt_q == '0) && w_hit;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_strb_q[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

    assign axi.ar_ready = (r_state_q == R_IDLE);
    assign axi.r_valid  = r_valid_q;
    assign axi.r_data   = r_data_q;
    assign axi.r_resp   = r_resp_q;
    assign axi.aw_ready = (w_state_q == W_IDLE) && !aw_got_q;
    assign axi.w_ready  = (w_state_q == W_IDLE) && !w_got_q;
    assign axi.b_valid  = b_valid_q;
    assign axi.b_resp   = b_resp_q;

endmodule

// File: tb/tb_axi_sram_slv.sv
// ----------------------------------------------------------------------------
// tb_axi_sram_slv
// Directed bench for axi_sram_slv with LATENCY=2.
// ----------------------------------------------------------------------------
module tb_axi_sram_slv;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    axi_sram_slv_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_sram_slv #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH_LOG2(10),
        .BASE      (32'h8000_0000),
        .LATENCY   (2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .axi  (axi)
    );

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int lat);
`ifdef AXI_SRAM_RAND_DELAY_EN
        check(tag, 32'(lat >= 2 && lat <= 5), 32'd1);
`else
        check(tag, 32'(lat), 32'd2);
`endif
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int lat, output logic [1:0] resp);
        int n = 0;
        axi.aw_addr  = a;
        axi.w_data   = d;
        axi.w_strb   = s;
        axi.aw_valid = 1'b1;
        axi.w_valid  = 1'b1;
        while (!(axi.aw_ready && axi.w_ready) && n < 50) begin tick; n++; end
        tick;
        axi.aw_valid = 1'b0;
        axi.w_valid  = 1'b0;
        lat = 0;
        while (!axi.b_valid && lat < 50) begin tick; lat++; end
        resp = axi.b_resp;
        axi.b_ready = 1'b1;
        tick;
        axi.b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int stall,
                            output int lat, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        axi.ar_addr  = a;
        axi.ar_valid = 1'b1;
        while (!axi.ar_ready && n < 50) begin tick; n++; end
        tick;
        axi.ar_valid = 1'b0;
        lat = 0;
        while (!axi.r_valid && lat < 50) begin tick; lat++; end
        d    = axi.r_data;
        resp = axi.r_resp;
        for (int i = 0; i < stall; i++) begin
            check("stall_rvalid", 32'(axi.r_valid), 32'd1);
            check("stall_rdata", axi.r_data, d);
            check("stall_arready", 32'(axi.ar_ready), 32'd0);
            tick;
        end
        axi.r_ready = 1'b1;
        tick;
        axi.r_ready = 1'b0;
    endtask

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [31:0] sb_data [8];
    int          trace_a [40];
    int          trace_b [40];
    int          addr_seq [40];
`endif

    initial begin
        int          lat;
        int          n;
        logic [31:0] d;
        logic [1:0]  resp;
        logic        stale;

        axi.ar_valid = 1'b0; axi.ar_addr = '0; axi.r_ready = 1'b0;
        axi.aw_valid = 1'b0; axi.aw_addr = '0;
        axi.w_valid  = 1'b0; axi.w_data  = '0; axi.w_strb = '0;
        axi.b_ready  = 1'b0;

        // Reset
        repeat (3) tick;
        rst_i = 1'b1;
        check("rst_ar_ready", 32'(axi.ar_ready), 32'd1);
        check("rst_aw_ready", 32'(axi.aw_ready), 32'd1);
        check("rst_w_ready",  32'(axi.w_ready),  32'd1);
        check("rst_r_valid",  32'(axi.r_valid),  32'd0);
        check("rst_b_valid",  32'(axi.b_valid),  32'd0);
        check("rst_r_data",   axi.r_data,        32'd0);
        check("rst_r_resp",   32'(axi.r_resp),   32'd0);
        check("rst_b_resp",   32'(axi.b_resp),   32'd0);

        // Full-word write then readback
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, resp);
        check_lat("wr1_lat", lat);
        check("wr1_resp", 32'(resp), 32'd0);
        axi_read(32'h8000_0010, 0, lat, d, resp);
        check_lat("rd1_lat", lat);
        check("rd1_data", d, 32'hDEAD_BEEF);
        check("rd1_resp", 32'(resp), 32'd0);

        // Low address bits ignored
        axi_read(32'h8000_0013, 0, lat, d, resp);
        check("rd_unaligned_data", d, 32'hDEAD_BEEF);

        // W before AW with partial strobe over zero
        axi_write(32'h8000_0020, 32'h0000_0000, 4'hF, lat, resp);
        axi.w_data  = 32'h1122_3344;
        axi.w_strb  = 4'b0101;
        axi.w_valid = 1'b1;
        tick;
        axi.w_valid = 1'b0;
        check("wfirst_w_ready",  32'(axi.w_ready),  32'd0);
        check("wfirst_aw_ready", 32'(axi.aw_ready), 32'd1);
        tick;
        tick;
        check("wfirst_no_b", 32'(axi.b_valid), 32'd0);
        axi.aw_addr  = 32'h8000_0020;
        axi.aw_valid = 1'b1;
        tick;
        axi.aw_valid = 1'b0;
        lat = 0;
        while (!axi.b_valid && lat < 50) begin tick; lat++; end
        check_lat("wfirst_lat", lat);
        check("wfirst_resp", 32'(axi.b_resp), 32'd0);
        axi.b_ready = 1'b1;
        tick;
        axi.b_ready = 1'b0;
        axi_read(32'h8000_0020, 0, lat, d, resp);
        check("wfirst_readback", d, 32'h0022_0044);

        // R back-pressure for 5 cycles
        axi_read(32'h8000_0010, 5, lat, d, resp);
        check("stall_data_value", d, 32'hDEAD_BEEF);
        check("post_r_hs_ar_ready", 32'(axi.ar_ready), 32'd1);
        check("post_r_hs_r_valid",  32'(axi.r_valid),  32'd0);

        // Out-of-range accesses
        axi_write(32'h8000_0000, 32'hA5A5_0000, 4'hF, lat, resp);
        axi_read(32'h7FFF_FFFC, 0, lat, d, resp);
        check_lat("oor_rd_lat", lat);
        check("oor_rd_resp", 32'(resp), 32'd3);
        check("oor_rd_data", d, 32'd0);
        axi_write(32'h8000_1000, 32'h5555_5555, 4'hF, lat, resp);
        check_lat("oor_wr_lat", lat);
        check("oor_wr_resp", 32'(resp), 32'd3);
        axi_read(32'h8000_0000, 0, lat, d, resp);
        check("oor_array_unchanged", d, 32'hA5A5_0000);
        axi_read(32'h8000_0FFC, 0, lat, d, resp);
        check("last_word_resp", 32'(resp), 32'd0);

        // Same-word read and write completing on the same edge
        axi_write(32'h8000_0030, 32'h0BAD_F00D, 4'hF, lat, resp);
        axi.ar_addr  = 32'h8000_0030;
        axi.aw_addr  = 32'h8000_0030;
        axi.w_data   = 32'h600D_CAFE;
        axi.w_strb   = 4'hF;
        axi.ar_valid = 1'b1;
        axi.aw_valid = 1'b1;
        axi.w_valid  = 1'b1;
        tick;
        axi.ar_valid = 1'b0;
        axi.aw_valid = 1'b0;
        axi.w_valid  = 1'b0;
        n = 0;
        while (!(axi.r_valid && axi.b_valid) && n < 50) begin tick; n++; end
        check("coll_both_valid", 32'(axi.r_valid && axi.b_valid), 32'd1);
        check("coll_old_data", axi.r_data, 32'h0BAD_F00D);
        axi.r_ready = 1'b1;
        axi.b_ready = 1'b1;
        tick;
        axi.r_ready = 1'b0;
        axi.b_ready = 1'b0;
        axi_read(32'h8000_0030, 0, lat, d, resp);
        check("coll_new_data", d, 32'h600D_CAFE);

        // Reset during R_WAIT
        axi.ar_addr  = 32'h8000_0010;
        axi.ar_valid = 1'b1;
        tick;
        axi.ar_valid = 1'b0;
        rst_i = 1'b0;
        tick;
        rst_i = 1'b1;
        check("rrst_r_valid",  32'(axi.r_valid),  32'd0);
        check("rrst_ar_ready", 32'(axi.ar_ready), 32'd1);
        stale = 1'b0;
        repeat (8) begin tick; if (axi.r_valid) stale = 1'b1; end
        check("rrst_no_stale_r", 32'(stale), 32'd0);

        // Reset on the commit edge of a pending write
        axi.aw_addr  = 32'h8000_0000;
        axi.w_data   = 32'hFFFF_FFFF;
        axi.w_strb   = 4'hF;
        axi.aw_valid = 1'b1;
        axi.w_valid  = 1'b1;
        tick;
        axi.aw_valid = 1'b0;
        axi.w_valid  = 1'b0;
        tick;
        rst_i = 1'b0;
        tick;
        rst_i = 1'b1;
        check("wrst_b_valid", 32'(axi.b_valid), 32'd0);
        stale = 1'b0;
        repeat (8) begin tick; if (axi.b_valid) stale = 1'b1; end
        check("wrst_no_stale_b", 32'(stale), 32'd0);
        axi_read(32'h8000_0000, 0, lat, d, resp);
        check("wrst_not_committed", d, 32'hA5A5_0000);

`ifdef AXI_SRAM_RAND_DELAY_EN
        for (int i = 0; i < 8; i++) begin
            sb_data[i] = 32'h1357_0000 + 32'(i * 32'h0101);
            axi_write(32'h8000_0100 + 32'(i * 4), sb_data[i], 4'hF, lat, resp);
        end
        for (int i = 0; i < 200; i++) begin
            int k;
            k = int'($urandom_range(0, 7));
            axi_read(32'h8000_0100 + 32'(k * 4), 0, lat, d, resp);
            check_lat("rand_lat", lat);
            check("rand_data", d, sb_data[k]);
        end
        for (int i = 0; i < 40; i++) addr_seq[i] = int'($urandom_range(0, 7));
        for (int pass = 0; pass < 2; pass++) begin
            rst_i = 1'b0;
            repeat (2) tick;
            rst_i = 1'b1;
            for (int i = 0; i < 40; i++) begin
                axi_read(32'h8000_0100 + 32'(addr_seq[i] * 4), 0, lat, d, resp);
                if (pass == 0) trace_a[i] = lat;
                else           trace_b[i] = lat;
            end
        end
        for (int i = 0; i < 40; i++) check("rand_trace_repeat", 32'(trace_b[i]), 32'(trace_a[i]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
